// File: rtl/llsc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llsc_pkg
// Description : Shared definitions for the LL/SC reservation controller.
//               Defines the commit op encoding, the LLBCTL CSR bit layout,
//               the reservation state encoding and the state record.
//               The record is carried between the snoop step and the two
//               slot steps.
// Revision    : 1.0 - initial release
// ============================================================================
package llsc_pkg;

  // Default physical address geometry. The resv_addr field in the state
  // record is sized from these values.
  localparam int LLSC_ADDR_W = 32;
  localparam int LLSC_GRAN_W = 4;
  localparam int LLSC_RESV_W = LLSC_ADDR_W - LLSC_GRAN_W;

  // Commit op encoding. Each slot carries one 3-bit op.
  // The values 5..7 are treated as NONE.
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LL    = 3'd1;
  localparam logic [2:0] OP_SC    = 3'd2;
  localparam logic [2:0] OP_ERTN  = 3'd3;
  localparam logic [2:0] OP_CSRWR = 3'd4;

  // LLBCTL CSR bit positions.
  localparam int LLBCTL_ROLLB = 0;
  localparam int LLBCTL_WCLLB = 1;
  localparam int LLBCTL_KLO   = 2;

  // The LLbit itself is the two-state reservation FSM.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_RESERVED = 1'b1
  } llsc_state_e;

  typedef struct packed {
    llsc_state_e              llbit;
    logic                     klo;
    logic [LLSC_RESV_W-1:0]   resv_addr;
  } llsc_state_t;

endpackage : llsc_pkg
`default_nettype wire

// File: rtl/llsc_slot_step.sv
`default_nettype none
// ============================================================================
// Module      : llsc_slot_step
// Description : Combinational next-state function for one commit slot.
//               It takes the reservation state as seen by this slot and
//               applies the slot's op. It returns the updated state and
//               whether an SC in this slot succeeds.
// Ports       : state_i     - reservation state before this slot
//               valid_i     - slot carries a committing instruction
//               op_i        - 3-bit op code
//               gran_i      - granule address (physical address >> GRAN_W)
//               csr_klo_i   - CSRWR data bit KLO
//               csr_wcllb_i - CSRWR data bit WCLLB
//               state_o     - reservation state after this slot
//               sc_ok_o     - SC in this slot succeeds
// Revision    : 1.0 - initial release
// ============================================================================
module llsc_slot_step
  import llsc_pkg::*;
(
  input  llsc_state_t              state_i,
  input  logic                     valid_i,
  input  logic [2:0]               op_i,
  input  logic [LLSC_RESV_W-1:0]   gran_i,
  input  logic                     csr_klo_i,
  input  logic                     csr_wcllb_i,
  output llsc_state_t              state_o,
  output logic                     sc_ok_o
);

  always_comb begin
    state_o = state_i;
    sc_ok_o = 1'b0;
    if (valid_i) begin
      case (op_i)
        OP_LL: begin
          state_o.llbit     = ST_RESERVED;
          state_o.resv_addr = gran_i;
        end
        OP_SC: begin
          // The reservation is consumed whether or not the SC succeeds.
          sc_ok_o       = (state_i.llbit == ST_RESERVED) &&
                          (gran_i == state_i.resv_addr);
          state_o.llbit = ST_IDLE;
        end
        OP_ERTN: begin
          // KLO protects the LLbit across exactly one exception return.
          if (state_i.klo) begin
            state_o.klo = 1'b0;
          end else begin
            state_o.llbit = ST_IDLE;
          end
        end
        OP_CSRWR: begin
          state_o.klo = csr_klo_i;
          if (csr_wcllb_i) begin
            state_o.llbit = ST_IDLE;
          end
        end
        default: begin
          // NONE and the reserved encodings leave the state untouched.
        end
      endcase
    end
  end

endmodule : llsc_slot_step
`default_nettype wire

// File: rtl/llsc_resv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : llsc_resv_ctrl
// Description : LL/SC reservation owner for the dual-issue commit stage.
//               On each cycle it applies a line-invalidation snoop and then
//               the two commit slots, in program order. It drives the SC
//               store enables combinationally. It returns the SC results
//               one cycle later for the rd writeback.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               cmt_valid[1:0]    - per-slot commit valid (bit0 = older)
//               cmt_op[5:0]       - {op1, op0}
//               cmt_addr          - {addr1, addr0} physical addresses
//               cmt_wdata[63:0]   - {wdata1, wdata0} CSRWR data
//               inval_valid/addr  - invalidation / eviction snoop
//               sc_store_en[1:0]  - SC may write memory (same cycle)
//               sc_result_valid   - registered SC completion, per slot
//               sc_result         - registered SC success, per slot
//               llbit             - current LLbit
//               llbctl_rdata      - LLBCTL CSR read value
// Revision    : 1.0 - initial release
// ============================================================================
module llsc_resv_ctrl
  import llsc_pkg::*;
#(
  parameter int ADDR_W = LLSC_ADDR_W,
  parameter int GRAN_W = LLSC_GRAN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmt_valid,
  input  logic [5:0]            cmt_op,
  input  logic [2*ADDR_W-1:0]   cmt_addr,
  input  logic [63:0]           cmt_wdata,
  input  logic                  inval_valid,
  input  logic [ADDR_W-1:0]     inval_addr,
  output logic [1:0]            sc_store_en,
  output logic [1:0]            sc_result_valid,
  output logic [1:0]            sc_result,
  output logic                  llbit,
  output logic [31:0]           llbctl_rdata
);

  llsc_state_t state_q;
  llsc_state_t state_d;
  llsc_state_t snoop_state;
  llsc_state_t slot0_state;

  logic [1:0]  sc_ok;
  logic [1:0]  sc_commit;
  logic [1:0]  sc_result_valid_q;
  logic [1:0]  sc_result_q;

  logic [2:0]  op0;
  logic [2:0]  op1;
  logic [ADDR_W-GRAN_W-1:0] gran0;
  logic [ADDR_W-GRAN_W-1:0] gran1;
  logic [ADDR_W-GRAN_W-1:0] inval_gran;

  // Only the granule bits of the addresses matter here. Of each CSR data
  // word, only the KLO and WCLLB bits matter. ROLLB is read-only.
  logic unused_inputs;
  assign unused_inputs = ^{cmt_addr[ADDR_W+GRAN_W-1:ADDR_W],
                           cmt_addr[GRAN_W-1:0],
                           inval_addr[GRAN_W-1:0],
                           cmt_wdata[63:35], cmt_wdata[32+LLBCTL_ROLLB],
                           cmt_wdata[31:3],  cmt_wdata[LLBCTL_ROLLB]};

  assign op0        = cmt_op[2:0];
  assign op1        = cmt_op[5:3];
  assign gran0      = cmt_addr[ADDR_W-1:GRAN_W];
  assign gran1      = cmt_addr[2*ADDR_W-1:ADDR_W+GRAN_W];
  assign inval_gran = inval_addr[ADDR_W-1:GRAN_W];

  // The snoop is applied first. This lets a same-cycle LL to the snooped
  // granule re-establish the reservation.
  always_comb begin
    snoop_state = state_q;
    if (inval_valid && (state_q.llbit == ST_RESERVED) &&
        (inval_gran == state_q.resv_addr)) begin
      snoop_state.llbit = ST_IDLE;
    end
  end

  llsc_slot_step u_slot0 (
    .state_i     (snoop_state),
    .valid_i     (cmt_valid[0]),
    .op_i        (op0),
    .gran_i      (gran0),
    .csr_klo_i   (cmt_wdata[LLBCTL_KLO]),
    .csr_wcllb_i (cmt_wdata[LLBCTL_WCLLB]),
    .state_o     (slot0_state),
    .sc_ok_o     (sc_ok[0])
  );

  // Slot 1 is younger, so it sees everything slot 0 did this cycle.
  llsc_slot_step u_slot1 (
    .state_i     (slot0_state),
    .valid_i     (cmt_valid[1]),
    .op_i        (op1),
    .gran_i      (gran1),
    .csr_klo_i   (cmt_wdata[32+LLBCTL_KLO]),
    .csr_wcllb_i (cmt_wdata[32+LLBCTL_WCLLB]),
    .state_o     (state_d),
    .sc_ok_o     (sc_ok[1])
  );

  assign sc_commit[0] = cmt_valid[0] && (op0 == OP_SC);
  assign sc_commit[1] = cmt_valid[1] && (op1 == OP_SC);

  // sc_ok is only ever raised for a valid SC, but gating it here keeps the
  // store-enable meaning self-evident.
  assign sc_store_en = sc_commit & sc_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= '0;
      sc_result_valid_q <= 2'b00;
      sc_result_q       <= 2'b00;
    end else begin
      state_q           <= state_d;
      sc_result_valid_q <= sc_commit;
      sc_result_q       <= sc_ok;
    end
  end

  assign sc_result_valid = sc_result_valid_q;
  assign sc_result       = sc_result_q;
  assign llbit           = (state_q.llbit == ST_RESERVED);
  assign llbctl_rdata    = {29'b0, state_q.klo, 1'b0, llbit};

endmodule : llsc_resv_ctrl
`default_nettype wire

// File: tb/tb_llsc_resv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_llsc_resv_ctrl
// Description : Directed self-checking bench for llsc_resv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llsc_resv_ctrl;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_LL    = 3'd1;
  localparam logic [2:0] C_SC    = 3'd2;
  localparam logic [2:0] C_ERTN  = 3'd3;
  localparam logic [2:0] C_CSRWR = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmt_valid;
  logic [5:0]  cmt_op;
  logic [63:0] cmt_addr;
  logic [63:0] cmt_wdata;
  logic        inval_valid;
  logic [31:0] inval_addr;
  logic [1:0]  sc_store_en;
  logic [1:0]  sc_result_valid;
  logic [1:0]  sc_result;
  logic        llbit;
  logic [31:0] llbctl_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  llsc_resv_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cmt_valid       (cmt_valid),
    .cmt_op          (cmt_op),
    .cmt_addr        (cmt_addr),
    .cmt_wdata       (cmt_wdata),
    .inval_valid     (inval_valid),
    .inval_addr      (inval_addr),
    .sc_store_en     (sc_store_en),
    .sc_result_valid (sc_result_valid),
    .sc_result       (sc_result),
    .llbit           (llbit),
    .llbctl_rdata    (llbctl_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cmt_valid   = 2'b00;
    cmt_op      = '0;
    cmt_addr    = '0;
    cmt_wdata   = '0;
    inval_valid = 1'b0;
    inval_addr  = '0;
  endtask

  task automatic slot(input int s, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd);
    cmt_valid[s]         = 1'b1;
    cmt_op[s*3 +: 3]     = op;
    cmt_addr[s*32 +: 32] = addr;
    cmt_wdata[s*32 +: 32] = wd;
  endtask

  // Advance one edge; outputs are sampled 1ns later, clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-op cycle on slot 0, inputs cleared afterwards.
  task automatic do1(input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wd);
    idle();
    slot(0, op, addr, wd);
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst_llbit",  {31'b0, llbit}, 32'd0);
    check("rst_rdata",  llbctl_rdata, 32'h0);
    check("rst_srv",    {30'b0, sc_result_valid}, 32'd0);
    check("rst_sr",     {30'b0, sc_result}, 32'd0);
    rst = 1'b0;

    // LL then SC to another word in the same 16-byte granule.
    do1(C_LL, 32'h1000_0040, 32'h0);
    check("ll_sets_llbit", {31'b0, llbit}, 32'd1);
    check("ll_rdata", llbctl_rdata, 32'h1);
    slot(0, C_SC, 32'h1000_004C, 32'h0);
    #1;
    check("sc_en_ok", {30'b0, sc_store_en}, 32'h1);
    tick();
    idle();
    check("sc_srv", {30'b0, sc_result_valid}, 32'h1);
    check("sc_res", {30'b0, sc_result}, 32'h1);
    check("sc_clears_llbit", {31'b0, llbit}, 32'd0);
    tick();
    check("srv_one_pulse", {30'b0, sc_result_valid}, 32'h0);

    // A snoop to a different granule leaves the reservation alone.
    do1(C_LL, 32'h2000_0000, 32'h0);
    inval_valid = 1'b1;
    inval_addr  = 32'h2000_0010;
    tick();
    idle();
    check("snoop_miss", {31'b0, llbit}, 32'd1);
    // A matching snoop kills it, and the later SC fails.
    inval_valid = 1'b1;
    inval_addr  = 32'h2000_0008;
    tick();
    idle();
    check("snoop_hit", {31'b0, llbit}, 32'd0);
    slot(0, C_SC, 32'h2000_0000, 32'h0);
    #1;
    check("sc_en_after_snoop", {30'b0, sc_store_en}, 32'h0);
    tick();
    idle();
    check("sc_srv_after_snoop", {30'b0, sc_result_valid}, 32'h1);
    check("sc_res_after_snoop", {30'b0, sc_result}, 32'h0);

    // A snoop with no reservation has no effect. Then a snoop and an LL to
    // the same granule arrive together, and the LL wins.
    inval_valid = 1'b1;
    inval_addr  = 32'h0000_0000;
    tick();
    idle();
    check("snoop_idle", {31'b0, llbit}, 32'd0);
    do1(C_LL, 32'h5000_0000, 32'h0);
    slot(0, C_LL, 32'h5000_0004, 32'h0);
    inval_valid = 1'b1;
    inval_addr  = 32'h5000_0000;
    tick();
    idle();
    check("snoop_vs_ll", {31'b0, llbit}, 32'd1);

    // LL in slot 0 and SC in slot 1 in the same cycle.
    idle();
    slot(0, C_LL, 32'h3000_0010, 32'h0);
    slot(1, C_SC, 32'h3000_0010, 32'h0);
    #1;
    check("ll_sc_pair_en", {30'b0, sc_store_en}, 32'h2);
    tick();
    idle();
    check("ll_sc_pair_srv", {30'b0, sc_result_valid}, 32'h2);
    check("ll_sc_pair_res", {30'b0, sc_result}, 32'h2);
    check("ll_sc_pair_llbit", {31'b0, llbit}, 32'd0);

    // Two SCs in one cycle: the younger always fails.
    do1(C_LL, 32'h3000_0020, 32'h0);
    slot(0, C_SC, 32'h3000_0020, 32'h0);
    slot(1, C_SC, 32'h3000_0020, 32'h0);
    #1;
    check("sc_sc_en", {30'b0, sc_store_en}, 32'h1);
    tick();
    idle();
    check("sc_sc_srv", {30'b0, sc_result_valid}, 32'h3);
    check("sc_sc_res", {30'b0, sc_result}, 32'h1);

    // KLO protects the LLbit across one ERTN.
    do1(C_LL, 32'h4000_0000, 32'h0);
    do1(C_CSRWR, 32'h0, 32'h4);
    check("klo_set", llbctl_rdata, 32'h5);
    do1(C_ERTN, 32'h0, 32'h0);
    check("ertn_klo", llbctl_rdata, 32'h1);
    do1(C_ERTN, 32'h0, 32'h0);
    check("ertn_noklo", llbctl_rdata, 32'h0);

    // Two ERTNs in one cycle: the first consumes KLO, the second clears LLbit.
    do1(C_LL, 32'h4000_0000, 32'h0);
    do1(C_CSRWR, 32'h0, 32'h4);
    slot(0, C_ERTN, 32'h0, 32'h0);
    slot(1, C_ERTN, 32'h0, 32'h0);
    tick();
    idle();
    check("ertn_pair", llbctl_rdata, 32'h0);

    // CSRWR sets KLO in slot 0, and ERTN in slot 1 consumes it.
    do1(C_LL, 32'h4000_0000, 32'h0);
    slot(0, C_CSRWR, 32'h0, 32'h4);
    slot(1, C_ERTN, 32'h0, 32'h0);
    tick();
    idle();
    check("csrwr_ertn", llbctl_rdata, 32'h1);

    // Writing WCLLB clears the reservation, so the next SC fails.
    do1(C_CSRWR, 32'h0, 32'h2);
    check("wcllb", llbctl_rdata, 32'h0);
    slot(0, C_SC, 32'h4000_0000, 32'h0);
    #1;
    check("sc_after_wcllb_en", {30'b0, sc_store_en}, 32'h0);
    tick();
    idle();
    check("sc_after_wcllb_res", {30'b0, sc_result}, 32'h0);

    // Reserved op codes and an SC with its valid low have no effect.
    do1(C_LL, 32'h6000_0000, 32'h0);
    cmt_valid = 2'b01;
    cmt_op    = 6'b000_111;
    tick();
    idle();
    check("op7_none", {31'b0, llbit}, 32'd1);
    cmt_valid = 2'b00;
    cmt_op    = {3'd0, C_SC};
    cmt_addr  = {32'h0, 32'h6000_0000};
    #1;
    check("sc_novalid_en", {30'b0, sc_store_en}, 32'h0);
    tick();
    idle();
    check("sc_novalid_srv", {30'b0, sc_result_valid}, 32'h0);
    check("sc_novalid_llbit", {31'b0, llbit}, 32'd1);

    // Reset mid-sequence while an SC commits in slot 1: the SC is dropped.
    do1(C_CSRWR, 32'h0, 32'h4);
    check("pre_rst_rdata", llbctl_rdata, 32'h5);
    rst = 1'b1;
    slot(1, C_SC, 32'h6000_0000, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    check("midrst_srv", {30'b0, sc_result_valid}, 32'h0);
    check("midrst_llbit", {31'b0, llbit}, 32'd0);
    check("midrst_rdata", llbctl_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_llsc_resv_ctrl
`default_nettype wire
